ay_bus_sequencer: RTL and testbench

//   Synchronous AY-3-8910 bus controller. Arbitrates two requesters (port 0 = CPU, port 1 = player)
//   and sequences each access onto the AY bus as latch-address -> gap -> write/read -> recovery,

---
 rtl/ay_bus_sequencer_if.sv | 33 +++
 rtl/ay_bus_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ay_bus_sequencer.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/ay_bus_sequencer_if.sv
// Bundle for the two requester ports and the AY-3-8910 bus side of ay_bus_sequencer.
// The master modport belongs to whoever drives requests and da_in; the slave modport belongs to the sequencer.
interface ay_bus_sequencer_if;
  logic       req0;
  logic       we0;
  logic [3:0] addr0;
  logic [7:0] wdata0;
  logic       ack0;
  logic       req1;
  logic       we1;
  logic [3:0] addr1;
  logic [7:0] wdata1;
  logic       ack1;
  logic [7:0] rdata;
  logic [7:0] da_out;
  logic       da_oe;
  logic [7:0] da_in;
  logic       bdir;
  logic       bc1;
  logic       bc2;
  logic       busy;
  logic       gnt;

  modport master (
    output req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, da_in,
    input  ack0, ack1, rdata, da_out, da_oe, bdir, bc1, bc2, busy, gnt
  );

  modport slave (
    input  req0, we0, addr0, wdata0, req1, we1, addr1, wdata1, da_in,
    output ack0, ack1, rdata, da_out, da_oe, bdir, bc1, bc2, busy, gnt
  );
endinterface

// File: rtl/ay_bus_sequencer.sv
// Two-port AY-3-8910 bus controller: arbitrates CPU/player requests and runs each access as
// latch-address, gap, write/read and recovery phases, with all bus controls driven from flops.
module ay_bus_sequencer #(
  parameter int T_AS       = 4,
  parameter int T_GAP      = 2,
  parameter int T_DW       = 4,
  parameter int T_RD       = 6,
  parameter int T_REC      = 2,
  parameter int ADDR_CACHE = 1
) (
  input  logic               clk,
  input  logic               rst,
  ay_bus_sequencer_if.slave  bus
);

  // Bus codes as {bdir, bc2, bc1}.
  localparam logic [2:0] CODE_INACTIVE = 3'b010;
  localparam logic [2:0] CODE_LATCH    = 3'b111;
  localparam logic [2:0] CODE_WRITE    = 3'b110;
  localparam logic [2:0] CODE_READ     = 3'b011;

  localparam logic [7:0] AS_LD  = (T_AS  > 1) ? 8'(T_AS  - 1) : 8'd0;
  localparam logic [7:0] GAP_LD = (T_GAP > 1) ? 8'(T_GAP - 1) : 8'd0;
  localparam logic [7:0] DW_LD  = (T_DW  > 1) ? 8'(T_DW  - 1) : 8'd0;
  localparam logic [7:0] RD_LD  = (T_RD  > 1) ? 8'(T_RD  - 1) : 8'd0;
  localparam logic [7:0] REC_LD = (T_REC > 1) ? 8'(T_REC - 1) : 8'd0;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_GAP, S_WR, S_RD, S_REC, S_ACK
  } state_t;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       port_q, port_nx;
  logic       we_q, we_nx;
  logic [3:0] addr_q, addr_nx;
  logic [7:0] wdata_q, wdata_nx;
  logic [3:0] cache_addr;
  logic       cache_valid;
  logic       cache_load;
  logic       rd_sample;
  logic [2:0] code_nx;
  logic       da_oe_nx;
  logic [7:0] da_out_nx;

  function automatic state_t data_state(input logic we);
    return we ? S_WR : S_RD;
  endfunction

  function automatic logic [7:0] load_value(input state_t s);
    case (s)
      S_ADDR:  return AS_LD;
      S_GAP:   return GAP_LD;
      S_WR:    return DW_LD;
      S_RD:    return RD_LD;
      S_REC:   return REC_LD;
      default: return 8'd0;
    endcase
  endfunction

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and infers a latch.
  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt - 8'd1;
    port_nx    = port_q;
    we_nx      = we_q;
    addr_nx    = addr_q;
    wdata_nx   = wdata_q;
    cache_load = 1'b0;
    rd_sample  = 1'b0;

    unique case (state)
      S_IDLE: begin
        if (bus.req0 || bus.req1) begin
          port_nx  = ~bus.req0;
          we_nx    = bus.req0 ? bus.we0    : bus.we1;
          addr_nx  = bus.req0 ? bus.addr0  : bus.addr1;
          wdata_nx = bus.req0 ? bus.wdata0 : bus.wdata1;
          if ((ADDR_CACHE != 0) && cache_valid && (addr_nx == cache_addr))
            state_nx = data_state(we_nx);
          else
            state_nx = S_ADDR;
        end
      end
      S_ADDR: if (cnt == 8'd0) begin
        cache_load = 1'b1;
        state_nx   = (T_GAP > 0) ? S_GAP : data_state(we_q);
      end
      S_GAP:  if (cnt == 8'd0) state_nx = data_state(we_q);
      S_WR:   if (cnt == 8'd0) state_nx = (T_REC > 0) ? S_REC : S_ACK;
      S_RD:   if (cnt == 8'd0) begin
        rd_sample = 1'b1;
        state_nx  = (T_REC > 0) ? S_REC : S_ACK;
      end
      S_REC:  if (cnt == 8'd0) state_nx = S_ACK;
      S_ACK:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase

    if (state_nx != state) cnt_nx = load_value(state_nx);

    // Outputs are decoded from the next state and registered, so codes only move on a clock edge.
    code_nx   = CODE_INACTIVE;
    da_oe_nx  = 1'b0;
    da_out_nx = 8'd0;
    case (state_nx)
      S_ADDR: begin
        code_nx   = CODE_LATCH;
        da_oe_nx  = 1'b1;
        da_out_nx = {4'h0, addr_nx};
      end
      S_WR: begin
        code_nx   = CODE_WRITE;
        da_oe_nx  = 1'b1;
        da_out_nx = wdata_nx;
      end
      S_RD:    code_nx = CODE_READ;
      default: ;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= 8'd0;
      port_q      <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= 4'd0;
      wdata_q     <= 8'd0;
      cache_addr  <= 4'd0;
      cache_valid <= 1'b0;
      bus.bdir    <= 1'b0;
      bus.bc2     <= 1'b1;
      bus.bc1     <= 1'b0;
      bus.da_oe   <= 1'b0;
      bus.da_out  <= 8'd0;
      bus.ack0    <= 1'b0;
      bus.ack1    <= 1'b0;
      bus.rdata   <= 8'd0;
      bus.busy    <= 1'b0;
      bus.gnt     <= 1'b0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      port_q  <= port_nx;
      we_q    <= we_nx;
      addr_q  <= addr_nx;
      wdata_q <= wdata_nx;
      if (cache_load) begin
        cache_addr  <= addr_q;
        cache_valid <= 1'b1;
      end
      bus.bdir   <= code_nx[2];
      bus.bc2    <= code_nx[1];
      bus.bc1    <= code_nx[0];
      bus.da_oe  <= da_oe_nx;
      bus.da_out <= da_out_nx;
      bus.ack0   <= (state_nx == S_ACK) && !port_nx;
      bus.ack1   <= (state_nx == S_ACK) && port_nx;
      if (rd_sample) bus.rdata <= bus.da_in;
      bus.busy   <= (state_nx != S_IDLE);
      bus.gnt    <= port_nx;
    end
  end

endmodule

// File: tb/tb_ay_bus_sequencer.sv
// Bench for ay_bus_sequencer: directed scenarios plus random accesses on a default instance and a
// no-cache/no-gap/no-recovery instance, each compared cycle by cycle against a phase-list model.
module tb_ay_bus_sequencer;

  localparam logic [2:0] C_INACT = 3'b010;
  localparam logic [2:0] C_LATCH = 3'b111;
  localparam logic [2:0] C_WRITE = 3'b110;
  localparam logic [2:0] C_READ  = 3'b011;
  localparam int AS = 4, DW = 4, RDW = 6;

  typedef struct packed {
    logic [2:0] code;
    logic       oe;
    logic [7:0] dout;
    logic       ack;
  } step_t;

  logic clk = 1'b0;
  logic rst_a, rst_b;
  logic mon_en = 1'b0;
  int   n_assert = 0;
  int   n_fail = 0;
  int   last_busy;

  step_t      trace[$];
  bit         cache_v[2];
  logic [3:0] cache_a[2];
  logic [7:0] rd_m[2];

  always #5 clk = ~clk;

  ay_bus_sequencer_if bus_a ();
  ay_bus_sequencer_if bus_b ();

  ay_bus_sequencer u_a (
    .clk (clk),
    .rst (rst_a),
    .bus (bus_a)
  );

  ay_bus_sequencer #(.T_GAP(0), .T_REC(0), .ADDR_CACHE(0)) u_b (
    .clk (clk),
    .rst (rst_b),
    .bus (bus_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input int dut, input int port, input logic req, input logic we,
                     input logic [3:0] addr, input logic [7:0] wd);
    if (dut == 0) begin
      if (port == 0) begin bus_a.req0 = req; bus_a.we0 = we; bus_a.addr0 = addr; bus_a.wdata0 = wd; end
      else           begin bus_a.req1 = req; bus_a.we1 = we; bus_a.addr1 = addr; bus_a.wdata1 = wd; end
    end else begin
      if (port == 0) begin bus_b.req0 = req; bus_b.we0 = we; bus_b.addr0 = addr; bus_b.wdata0 = wd; end
      else           begin bus_b.req1 = req; bus_b.we1 = we; bus_b.addr1 = addr; bus_b.wdata1 = wd; end
    end
  endtask

  task automatic set_dain(input int dut, input logic [7:0] v);
    if (dut == 0) bus_a.da_in = v;
    else          bus_b.da_in = v;
  endtask

  task automatic get(input int dut, output logic [2:0] code, output logic oe, output logic [7:0] dout,
                     output logic a0, output logic a1, output logic bsy, output logic g,
                     output logic [7:0] rd);
    if (dut == 0) begin
      code = {bus_a.bdir, bus_a.bc2, bus_a.bc1}; oe = bus_a.da_oe; dout = bus_a.da_out;
      a0 = bus_a.ack0; a1 = bus_a.ack1; bsy = bus_a.busy; g = bus_a.gnt; rd = bus_a.rdata;
    end else begin
      code = {bus_b.bdir, bus_b.bc2, bus_b.bc1}; oe = bus_b.da_oe; dout = bus_b.da_out;
      a0 = bus_b.ack0; a1 = bus_b.ack1; bsy = bus_b.busy; g = bus_b.gnt; rd = bus_b.rdata;
    end
  endtask

  // Expected per-cycle bus activity of one access, built from the phase widths and the cache rule.
  function automatic void build(input int dut, input logic we, input logic [3:0] addr, input logic [7:0] wd);
    int  gap = (dut == 0) ? 2 : 0;
    int  rec = (dut == 0) ? 2 : 0;
    bit  hit = (dut == 0) && cache_v[dut] && (cache_a[dut] == addr);
    trace.delete();
    if (!hit) begin
      repeat (AS)  trace.push_back('{C_LATCH, 1'b1, {4'h0, addr}, 1'b0});
      repeat (gap) trace.push_back('{C_INACT, 1'b0, 8'h00, 1'b0});
      cache_v[dut] = 1'b1;
      cache_a[dut] = addr;
    end
    if (we) repeat (DW)  trace.push_back('{C_WRITE, 1'b1, wd, 1'b0});
    else    repeat (RDW) trace.push_back('{C_READ, 1'b0, 8'h00, 1'b0});
    repeat (rec) trace.push_back('{C_INACT, 1'b0, 8'h00, 1'b0});
    trace.push_back('{C_INACT, 1'b0, 8'h00, 1'b1});
  endfunction

  // Starts on the cycle after the grant edge; scrambles the granted port's inputs after the grant
  // and drops its request in the ack cycle.
  task automatic expect_trace(input int dut, input int port, input logic we, input logic [3:0] addr,
                              input logic [7:0] wd, input logic [7:0] dain);
    logic [2:0] code;
    logic       oe, a0, a1, bsy, g;
    logic [7:0] dout, rd;
    int         n_busy = 0;
    build(dut, we, addr, wd);
    foreach (trace[i]) begin
      @(negedge clk);
      get(dut, code, oe, dout, a0, a1, bsy, g, rd);
      if (bsy === 1'b1) n_busy++;
      check("busy", 32'(bsy), 32'd1);
      check("gnt", 32'(g), 32'(port));
      check("bus_code", 32'(code), 32'(trace[i].code));
      check("da_oe", 32'(oe), 32'(trace[i].oe));
      if (trace[i].oe) check("da_out", 32'(dout), 32'(trace[i].dout));
      check("ack0", 32'(a0), 32'(trace[i].ack && port == 0));
      check("ack1", 32'(a1), 32'(trace[i].ack && port == 1));
      if (trace[i].ack) begin
        if (!we) rd_m[dut] = dain;
        check("rdata", 32'(rd), 32'(rd_m[dut]));
        drv(dut, port, 1'b0, 1'($urandom), 4'($urandom), 8'($urandom));
      end else if (i == 0) begin
        drv(dut, port, 1'b1, 1'($urandom), 4'($urandom), 8'($urandom));
      end
    end
    check("latency", 32'(n_busy), 32'(trace.size()));
    last_busy = n_busy;
  endtask

  task automatic idle_check(input int dut);
    logic [2:0] code;
    logic       oe, a0, a1, bsy, g;
    logic [7:0] dout, rd;
    @(negedge clk);
    get(dut, code, oe, dout, a0, a1, bsy, g, rd);
    check("idle_busy", 32'(bsy), 32'd0);
    check("idle_code", 32'(code), 32'(C_INACT));
    check("idle_oe", 32'(oe), 32'd0);
    check("idle_ack", 32'({a0, a1}), 32'd0);
  endtask

  // Bus-wide invariants on both instances every cycle once out of the initial reset.
  always @(negedge clk) begin
    logic [2:0] ca, cb;
    if (mon_en) begin
      ca = {bus_a.bdir, bus_a.bc2, bus_a.bc1};
      cb = {bus_b.bdir, bus_b.bc2, bus_b.bc1};
      check("legal_code_a", 32'(ca inside {C_INACT, C_LATCH, C_WRITE, C_READ}), 32'd1);
      check("legal_code_b", 32'(cb inside {C_INACT, C_LATCH, C_WRITE, C_READ}), 32'd1);
      check("oe_in_read_a", 32'(bus_a.da_oe && ca == C_READ), 32'd0);
      check("oe_in_read_b", 32'(bus_b.da_oe && cb == C_READ), 32'd0);
    end
  end

  initial begin
    logic [2:0] code;
    logic       oe, a0, a1, bsy, g;
    logic [7:0] dout, rd;

    rst_a = 1'b1;
    rst_b = 1'b1;
    for (int d = 0; d < 2; d++) begin
      drv(d, 0, 1'b0, 1'b0, 4'h0, 8'h00);
      drv(d, 1, 1'b0, 1'b0, 4'h0, 8'h00);
      set_dain(d, 8'h00);
      cache_v[d] = 1'b0;
      cache_a[d] = 4'h0;
      rd_m[d]    = 8'h00;
    end
    repeat (2) @(negedge clk);

    // Reset state on both instances.
    for (int d = 0; d < 2; d++) begin
      get(d, code, oe, dout, a0, a1, bsy, g, rd);
      check("rst_code", 32'(code), 32'(C_INACT));
      check("rst_oe", 32'(oe), 32'd0);
      check("rst_dout", 32'(dout), 32'd0);
      check("rst_ack", 32'({a0, a1}), 32'd0);
      check("rst_busy", 32'(bsy), 32'd0);
      check("rst_gnt", 32'(g), 32'd0);
      check("rst_rdata", 32'(rd), 32'd0);
    end
    rst_a  = 1'b0;
    rst_b  = 1'b0;
    mon_en = 1'b1;

    // Port 0 write, cold cache: full sequence of 13 busy cycles.
    drv(0, 0, 1'b1, 1'b1, 4'd7, 8'h3E);
    expect_trace(0, 0, 1'b1, 4'd7, 8'h3E, 8'h00);
    check("t1_latency", 32'(last_busy), 32'd13);
    idle_check(0);

    // Port 0 read of the same register: cache hit skips the address phase.
    set_dain(0, 8'hA5);
    drv(0, 0, 1'b1, 1'b0, 4'd7, 8'h00);
    expect_trace(0, 0, 1'b0, 4'd7, 8'h00, 8'hA5);
    check("t2_latency", 32'(last_busy), 32'd9);
    idle_check(0);

    // Simultaneous requests: port 0 first, one idle cycle, then port 1.
    set_dain(0, 8'h5C);
    drv(0, 0, 1'b1, 1'b1, 4'd3, 8'h11);
    drv(0, 1, 1'b1, 1'b0, 4'd9, 8'h00);
    expect_trace(0, 0, 1'b1, 4'd3, 8'h11, 8'h5C);
    idle_check(0);
    expect_trace(0, 1, 1'b0, 4'd9, 8'h00, 8'h5C);
    idle_check(0);

    // Reset in the middle of the write phase aborts the access and invalidates the cache.
    drv(0, 0, 1'b1, 1'b1, 4'd12, 8'h77);
    repeat (AS + 2 + 2) @(negedge clk);
    get(0, code, oe, dout, a0, a1, bsy, g, rd);
    check("t4_in_write", 32'(code), 32'(C_WRITE));
    rst_a = 1'b1;
    drv(0, 0, 1'b0, 1'b0, 4'd0, 8'h00);
    @(negedge clk);
    get(0, code, oe, dout, a0, a1, bsy, g, rd);
    check("t4_rst_code", 32'(code), 32'(C_INACT));
    check("t4_rst_oe", 32'(oe), 32'd0);
    check("t4_rst_busy", 32'(bsy), 32'd0);
    check("t4_rst_ack", 32'({a0, a1}), 32'd0);
    check("t4_rst_rdata", 32'(rd), 32'd0);
    rst_a      = 1'b0;
    cache_v[0] = 1'b0;
    rd_m[0]    = 8'h00;
    repeat (3) idle_check(0);
    drv(0, 0, 1'b1, 1'b1, 4'd12, 8'h77);
    expect_trace(0, 0, 1'b1, 4'd12, 8'h77, 8'h00);
    check("t4_relatch_latency", 32'(last_busy), 32'd13);
    idle_check(0);

    // No cache, no gap, no recovery: two writes to the same register both latch, 9 cycles each.
    drv(1, 0, 1'b1, 1'b1, 4'd2, 8'hAA);
    expect_trace(1, 0, 1'b1, 4'd2, 8'hAA, 8'h00);
    check("t5_latency_1", 32'(last_busy), 32'd9);
    idle_check(1);
    drv(1, 0, 1'b1, 1'b1, 4'd2, 8'h55);
    expect_trace(1, 0, 1'b1, 4'd2, 8'h55, 8'h00);
    check("t5_latency_2", 32'(last_busy), 32'd9);
    idle_check(1);

    // Random accesses on both instances, occasionally with both ports contending.
    for (int n = 0; n < 40; n++) begin
      int         d    = int'($urandom_range(0, 1));
      int         p    = int'($urandom_range(0, 1));
      bit         dual = ($urandom_range(0, 3) == 0);
      logic       we0  = 1'($urandom);
      logic       we1  = 1'($urandom);
      logic [3:0] ad0  = 4'($urandom_range(0, 3));
      logic [3:0] ad1  = 4'($urandom_range(0, 3));
      logic [7:0] wd0  = 8'($urandom);
      logic [7:0] wd1  = 8'($urandom);
      logic [7:0] din  = 8'($urandom);
      set_dain(d, din);
      if (dual) begin
        drv(d, 0, 1'b1, we0, ad0, wd0);
        drv(d, 1, 1'b1, we1, ad1, wd1);
        expect_trace(d, 0, we0, ad0, wd0, din);
        idle_check(d);
        expect_trace(d, 1, we1, ad1, wd1, din);
      end else begin
        drv(d, p, 1'b1, we0, ad0, wd0);
        expect_trace(d, p, we0, ad0, wd0, din);
      end
      idle_check(d);
    end

    mon_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
